// File: rtl/aes_request_scheduler_pkg.sv
// Shared AES definitions: block/key types, engine op encoding and default engine latency.
package aes_request_scheduler_pkg;

    typedef logic [127:0] state_t;
    typedef logic [127:0] key_t;

    typedef enum logic {
        ENCRYPT = 1'b0,
        DECRYPT = 1'b1
    } aes_op_t;

    localparam int AES_ENGINE_LATENCY = 11;

endpackage

// File: rtl/aes_request_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from ptr, ptr moves past each winner.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] cand;
    logic             found;
    int               cand_i;

    always_comb begin
        grant  = '0;
        idx    = '0;
        found  = 1'b0;
        cand   = '0;
        cand_i = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_i = int'(ptr_q) + k;
            if (cand_i >= NUM_REQ) cand_i = cand_i - NUM_REQ;
            cand = IDX_W'(cand_i);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && found)
            ptr_d = (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/aes_request_scheduler.sv
// Shares one AES encoder and one decoder among NUM_REQ requesters; a tag pipe matching the
// engine latency routes each result back to its requester on a single response port.
module aes_request_scheduler
    import aes_request_scheduler_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int LATENCY = AES_ENGINE_LATENCY,
    localparam int TAG_W   = $clog2(NUM_REQ)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   reqValid,
    output logic [NUM_REQ-1:0]   reqReady,
    input  logic [NUM_REQ-1:0]   reqOp,
    input  state_t [NUM_REQ-1:0] reqData,
    input  key_t   [NUM_REQ-1:0] reqKey,
    output state_t               encData,
    output key_t                 encKey,
    output state_t               decData,
    output key_t                 decKey,
    input  state_t               encResult,
    input  state_t               decResult,
    input  logic                 encValid,
    input  logic                 decValid,
    output logic                 rspValid,
    output logic [TAG_W-1:0]     rspId,
    output logic                 rspOp,
    output state_t               rspData,
    output logic                 busy,
    output logic                 err
);

    typedef struct packed {
        logic             valid;
        aes_op_t          op;
        logic [TAG_W-1:0] id;
    } sched_tag_t;

    logic [NUM_REQ-1:0] gnt;
    logic [TAG_W-1:0]   gnt_idx;
    logic               hs;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clock   (clock),
        .reset   (reset),
        .req     (reqValid),
        .advance (hs),
        .grant   (gnt),
        .idx     (gnt_idx)
    );

    assign reqReady = gnt;
    assign hs       = |gnt;

    state_t enc_data_q, enc_data_d, dec_data_q, dec_data_d;
    key_t   enc_key_q, enc_key_d, dec_key_q, dec_key_d;

    // The idle engine sees all-zero inputs, so stale blocks never linger on its ports.
    always_comb begin
        enc_data_d = '0;
        enc_key_d  = '0;
        dec_data_d = '0;
        dec_key_d  = '0;
        if (hs) begin
            if (reqOp[gnt_idx]) begin
                dec_data_d = reqData[gnt_idx];
                dec_key_d  = reqKey[gnt_idx];
            end else begin
                enc_data_d = reqData[gnt_idx];
                enc_key_d  = reqKey[gnt_idx];
            end
        end
    end

    sched_tag_t tag_q [LATENCY+1];
    sched_tag_t tag_d [LATENCY+1];
    sched_tag_t due;

    always_comb begin
        tag_d[0] = '0;
        if (hs) tag_d[0] = '{valid: 1'b1, op: aes_op_t'(reqOp[gnt_idx]), id: gnt_idx};
        for (int k = 1; k <= LATENCY; k++) tag_d[k] = tag_q[k-1];
    end

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k <= LATENCY; k++) busy = busy | tag_q[k].valid;
    end

    // Final stage is aligned with the engine output cycle.
    assign due = tag_q[LATENCY];

    logic             rsp_valid_q, rsp_valid_d;
    logic [TAG_W-1:0] rsp_id_q, rsp_id_d;
    logic             rsp_op_q, rsp_op_d;
    state_t           rsp_data_q, rsp_data_d;
    logic             err_q, err_d;

    always_comb begin
        rsp_valid_d = due.valid;
        rsp_id_d    = '0;
        rsp_op_d    = 1'b0;
        rsp_data_d  = '0;
        err_d       = err_q;
        if (due.valid) begin
            rsp_id_d = due.id;
            rsp_op_d = (due.op == DECRYPT);
            if (due.op == DECRYPT) begin
                rsp_data_d = decResult;
                err_d      = err_q | ~decValid;
            end else begin
                rsp_data_d = encResult;
                err_d      = err_q | ~encValid;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            enc_data_q  <= '0;
            enc_key_q   <= '0;
            dec_data_q  <= '0;
            dec_key_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_op_q    <= 1'b0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
            for (int k = 0; k <= LATENCY; k++) tag_q[k] <= '0;
        end else begin
            enc_data_q  <= enc_data_d;
            enc_key_q   <= enc_key_d;
            dec_data_q  <= dec_data_d;
            dec_key_q   <= dec_key_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_op_q    <= rsp_op_d;
            rsp_data_q  <= rsp_data_d;
            err_q       <= err_d;
            for (int k = 0; k <= LATENCY; k++) tag_q[k] <= tag_d[k];
        end
    end

    assign encData  = enc_data_q;
    assign encKey   = enc_key_q;
    assign decData  = dec_data_q;
    assign decKey   = dec_key_q;
    assign rspValid = rsp_valid_q;
    assign rspId    = rsp_id_q;
    assign rspOp    = rsp_op_q;
    assign rspData  = rsp_data_q;
    assign err      = err_q;

endmodule
